// File: rtl/hack_pkg.sv
// Shared definitions for the Hack-compatible cores: FSM states and
// instruction field positions.
package hack_pkg;
   typedef enum logic [2:0] {FETCH, DECODE, MRD, EXEC, MWR, HALT} state_t;

   localparam int A_BIT    = 12;
   localparam int COMP_LSB = 6;
   localparam int DEST_LSB = 3;
   localparam int JUMP_LSB = 0;

   localparam logic [2:0] JMP = 3'b111;
endpackage

// File: rtl/hack_alu.sv
// Hack ALU at arbitrary width. comp is {zx, nx, zy, ny, f, no}.
module hack_alu #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic [5:0]        comp,
   output logic [DATA_W-1:0] out,
   output logic              zr,
   output logic              ng
);
   logic [DATA_W-1:0] x_z, x_n, y_z, y_n, f_out;

   always_comb begin
      x_z   = comp[5] ? '0 : x;
      x_n   = comp[4] ? ~x_z : x_z;
      y_z   = comp[3] ? '0 : y;
      y_n   = comp[2] ? ~y_z : y_z;
      f_out = comp[1] ? (x_n + y_n) : (x_n & y_n);
      out   = comp[0] ? ~f_out : f_out;
      zr    = (out == '0);
      ng    = out[DATA_W-1];
   end
endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with req/ack instruction and data memory ports,
// self-jump halt detection and a per-instruction retire pulse.
//
// state  | meaning
// FETCH  | imem_req held until imem_ack, IR latched
// DECODE | A-instr retires here; C-instr picks MRD or EXEC
// MRD    | dmem read of M at A, MDR latched on ack
// EXEC   | ALU, D/A update, jump evaluation; MWR if dest has M
// MWR    | dmem write of ALU result at pre-update A
// HALT   | taken JMP onto its own pc; idle until reset
module hack_cpu_mc
   import hack_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 15,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              CLK,
   input  logic              reset_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic              retired,
   output logic              halted
);
   state_t            state;
   logic [DATA_W-1:0] ir, a_reg, d_reg, mdr;
   logic [ADDR_W-1:0] addr_q;
   logic              taken_q;

   logic [DATA_W-1:0] alu_out;
   logic              alu_zr, alu_ng;
   logic [2:0]        jump;
   logic              taken, finish, fin_taken, fin_halt;
   logic [ADDR_W-1:0] fin_target;

   hack_alu #(.DATA_W(DATA_W)) u_alu (
      .x    (d_reg),
      .y    (ir[A_BIT] ? mdr : a_reg),
      .comp (ir[COMP_LSB +: 6]),
      .out  (alu_out),
      .zr   (alu_zr),
      .ng   (alu_ng)
   );

   assign imem_addr = pc;
   assign jump      = ir[JUMP_LSB +: 3];
   assign taken     = (jump[2] & alu_ng) | (jump[1] & alu_zr) | (jump[0] & ~alu_zr & ~alu_ng);

   // EXEC retires directly from live ALU flags; MWR uses the copies taken in EXEC.
   always_comb begin
      finish     = ((state == EXEC) && !ir[DEST_LSB]) || ((state == MWR) && dmem_ack);
      fin_taken  = (state == MWR) ? taken_q : taken;
      fin_target = (state == MWR) ? addr_q : a_reg[ADDR_W-1:0];
      fin_halt   = fin_taken && (jump == JMP) && (fin_target == pc);
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         ir         <= '0;
         a_reg      <= '0;
         d_reg      <= '0;
         mdr        <= '0;
         addr_q     <= '0;
         taken_q    <= 1'b0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         retired    <= 1'b0;
         halted     <= 1'b0;
      end else begin
         retired <= 1'b0;
         case (state)
            FETCH: begin
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= DECODE;
               end
            end
            DECODE: begin
               if (!ir[DATA_W-1]) begin
                  a_reg    <= {1'b0, ir[DATA_W-2:0]};
                  pc       <= pc + ADDR_W'(1);
                  retired  <= 1'b1;
                  imem_req <= 1'b1;
                  state    <= FETCH;
               end else if (ir[A_BIT]) begin
                  dmem_req  <= 1'b1;
                  dmem_we   <= 1'b0;
                  dmem_addr <= a_reg[ADDR_W-1:0];
                  state     <= MRD;
               end else begin
                  state <= EXEC;
               end
            end
            MRD: begin
               if (dmem_ack) begin
                  mdr      <= dmem_rdata;
                  dmem_req <= 1'b0;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               addr_q  <= a_reg[ADDR_W-1:0];
               taken_q <= taken;
               if (ir[DEST_LSB+1]) d_reg <= alu_out;
               if (ir[DEST_LSB+2]) a_reg <= alu_out;
               if (ir[DEST_LSB]) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= 1'b1;
                  dmem_addr  <= a_reg[ADDR_W-1:0];
                  dmem_wdata <= alu_out;
                  state      <= MWR;
               end
            end
            MWR: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
               end
            end
            HALT: ;
            default: state <= FETCH;
         endcase

         if (finish) begin
            retired <= 1'b1;
            if (fin_halt) begin
               halted <= 1'b1;
               state  <= HALT;
            end else begin
               pc       <= fin_taken ? fin_target : pc + ADDR_W'(1);
               imem_req <= 1'b1;
               state    <= FETCH;
            end
         end
      end
   end
endmodule
